// File: rtl/vga_mem_clr.sv
// vga_mem_clr: dual-port RAM (A read/write, B read-only) with a whole-memory fill engine
// clk, rst_n             : rising-edge clock, synchronous active-low reset
// data_a/addr_a/we_a/q_a : port A write data, address, write enable, registered read data
// addr_b/q_b             : port B address, registered read data
// clr_start/clr_value    : fill request and fill word (sampled together in IDLE)
// clr_busy/clr_done      : fill in progress, one-cycle completion pulse
module vga_mem_clr #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 2 ** ADDR_W,
  parameter int RDW_NEW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              we_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] q_b,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_val;
  logic              w_clr, w_a_ok, w_b_ok, w_we, w_fwd_a, w_fwd_b;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  // The fill engine owns the single write path while clearing; port A may
  // only write from IDLE. Gating with rst_n keeps an aborted fill from
  // writing one extra word on the reset edge.
  always_comb begin
    w_clr    = r_state == S_CLEAR;
    w_a_ok   = {1'b0, addr_a} < LIM;
    w_b_ok   = {1'b0, addr_b} < LIM;
    w_we     = rst_n && (w_clr || (r_state == S_IDLE && we_a && w_a_ok));
    w_waddr  = w_clr ? r_ptr : addr_a;
    w_wdata  = w_clr ? r_val : data_a;
    w_fwd_a  = RDW_NEW != 0 && w_we && w_waddr == addr_a;
    w_fwd_b  = RDW_NEW != 0 && w_we && w_waddr == addr_b;
    clr_busy = w_clr;
    clr_done = r_state == S_DONE;
  end
  always_ff @(posedge clk)
    if (w_we) r_mem[w_waddr[IW-1:0]] <= w_wdata;
  always_ff @(posedge clk)
    if (!rst_n) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= !w_a_ok ? '0 : w_fwd_a ? w_wdata : r_mem[addr_a[IW-1:0]];
      q_b <= !w_b_ok ? '0 : w_fwd_b ? w_wdata : r_mem[addr_b[IW-1:0]];
    end
  always_ff @(posedge clk)
    if (r_state == S_IDLE && clr_start) r_val <= clr_value;
  // The pointer holds at DEPTH-1 on the last fill write instead of wrapping.
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else if (r_state == S_IDLE && clr_start) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else if (w_clr) begin
      if (r_ptr == LAST) r_state <= S_DONE;
      else r_ptr <= r_ptr + ADDR_W'(1);
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
    end
endmodule

// File: tb/tb_vga_mem_clr.sv
// tb_vga_mem_clr: randomized + directed scoreboard bench for two vga_mem_clr configurations
module tb_vga_mem_clr;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, we_a, clr_start;
  logic [7:0]  data_a, clr_value;
  logic [11:0] addr_a, addr_b;
  logic [7:0]  q_a0, q_b0, q_a1, q_b1;
  logic        busy0, busy1, done0, done1;
  int          n_chk = 0, n_pass = 0, nb, nd;
  vga_mem_clr #(.DATA_W(8), .ADDR_W(12), .DEPTH(2048), .RDW_NEW(1)) u0 (
    .clk(clk), .rst_n(rst_n), .data_a(data_a), .addr_a(addr_a), .we_a(we_a), .q_a(q_a0),
    .addr_b(addr_b), .q_b(q_b0), .clr_start(clr_start), .clr_value(clr_value),
    .clr_busy(busy0), .clr_done(done0));
  vga_mem_clr #(.DATA_W(8), .ADDR_W(12), .DEPTH(16), .RDW_NEW(0)) u1 (
    .clk(clk), .rst_n(rst_n), .data_a(data_a), .addr_a(addr_a), .we_a(we_a), .q_a(q_a1),
    .addr_b(addr_b), .q_b(q_b1), .clr_start(clr_start), .clr_value(clr_value),
    .clr_busy(busy1), .clr_done(done1));
  typedef struct packed {logic [7:0] qa, qb; logic ka, kb, busy, done;} exp_t;
  exp_t       sb0[$], sb1[$];
  logic [7:0] mm [2][2048];
  bit         mk [2][2048];
  int         dep [2] = '{2048, 16};
  bit         rdw [2] = '{1'b1, 1'b0};
  int         fpos [2] = '{-1, -1};
  bit         dph [2];
  logic [7:0] fv [2];
  function automatic exp_t step(int i);
    exp_t e;
    bit wen;
    int wa, a, b;
    logic [7:0] wd;
    e = '0;
    a = int'(addr_a);
    b = int'(addr_b);
    if (!rst_n) begin
      fpos[i] = -1;
      dph[i] = 1'b0;
      e.ka = 1'b1;
      e.kb = 1'b1;
      return e;
    end
    wen = 1'b0; wa = 0; wd = '0;
    if (fpos[i] >= 0) begin wen = 1'b1; wa = fpos[i]; wd = fv[i]; end
    else if (!dph[i] && we_a && a < dep[i]) begin wen = 1'b1; wa = a; wd = data_a; end
    if (a >= dep[i]) begin e.qa = '0; e.ka = 1'b1; end
    else if (rdw[i] && wen && wa == a) begin e.qa = wd; e.ka = 1'b1; end
    else begin e.qa = mm[i][a]; e.ka = mk[i][a]; end
    if (b >= dep[i]) begin e.qb = '0; e.kb = 1'b1; end
    else if (rdw[i] && wen && wa == b) begin e.qb = wd; e.kb = 1'b1; end
    else begin e.qb = mm[i][b]; e.kb = mk[i][b]; end
    if (fpos[i] >= 0) begin
      if (fpos[i] == dep[i] - 1) begin fpos[i] = -1; dph[i] = 1'b1; end
      else fpos[i]++;
    end else if (dph[i]) dph[i] = 1'b0;
    else if (clr_start) begin fpos[i] = 0; fv[i] = clr_value; end
    if (wen) begin mm[i][wa] = wd; mk[i][wa] = 1'b1; end
    e.busy = fpos[i] >= 0;
    e.done = dph[i];
    return e;
  endfunction
  task automatic chk(string nm, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
  endtask
  task automatic cmp(string u, exp_t e, logic [7:0] qa, logic [7:0] qb, logic b, logic d);
    if (e.ka) chk({u, " q_a"}, int'(qa), int'(e.qa));
    if (e.kb) chk({u, " q_b"}, int'(qb), int'(e.qb));
    chk({u, " clr_busy"}, int'(b), int'(e.busy));
    chk({u, " clr_done"}, int'(d), int'(e.done));
  endtask
  always @(negedge clk) begin
    if (sb0.size() > 0) cmp("u0", sb0.pop_front(), q_a0, q_b0, busy0, done0);
    if (sb1.size() > 0) cmp("u1", sb1.pop_front(), q_a1, q_b1, busy1, done1);
  end
  task automatic cyc();
    @(posedge clk);
    sb0.push_back(step(0));
    sb1.push_back(step(1));
    #1;
  endtask
  task automatic put(logic we, logic [11:0] aa, logic [7:0] da, logic [11:0] ab);
    we_a = we; addr_a = aa; data_a = da; addr_b = ab;
    cyc();
  endtask
  initial begin
    rst_n = 1'b0; we_a = 1'b0; clr_start = 1'b0; data_a = '0; clr_value = '0;
    addr_a = '0; addr_b = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    clr_value = 8'h11; clr_start = 1'b1; cyc(); clr_start = 1'b0;
    repeat (2052) cyc();
    put(1, 0, 200, 5); put(0, 0, 0, 0); put(0, 0, 0, 0);
    put(1, 23, 37, 0); put(1, 24, 5, 0); put(0, 23, 0, 24);
    put(1, 1, 9, 0); put(1, 1, 37, 1); put(0, 0, 0, 1);
    for (int i = 0; i < 2096; i++) begin
      put(1, 12'(i), i < 2048 ? i[7:0] : ~i[7:0], 12'(i));
      put(0, 12'(i), 0, 12'(i));
    end
    for (int i = 0; i < 64; i++) put(0, 12'(i), 0, 12'(63 - i));
    we_a = 1'b0; nb = 0; nd = 0;
    clr_value = 8'hAA; clr_start = 1'b1; cyc(); clr_start = 1'b0;
    nb += int'(busy1);
    for (int c = 0; c < 20; c++) begin
      we_a = c >= 2 && c < 8; addr_a = 12'(c % 16); data_a = 8'h33; addr_b = 12'(c);
      clr_start = c == 4; clr_value = c == 4 ? 8'h55 : 8'hAA;
      cyc();
      nb += int'(busy1); nd += int'(done1);
    end
    clr_start = 1'b0; we_a = 1'b0;
    chk("fill busy cycles", nb, 16);
    chk("fill done pulses", nd, 1);
    for (int i = 0; i < 16; i++) put(0, 12'(i), 0, 12'(15 - i));
    for (int i = 0; i < 16; i++) put(1, 12'(i), 8'(8'h40 + i), 12'(i));
    we_a = 1'b0;
    clr_value = 8'h5C; clr_start = 1'b1; cyc(); clr_start = 1'b0;
    repeat (5) cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    nb = int'(busy1); nd = int'(done1);
    repeat (20) begin cyc(); nb += int'(busy1); nd += int'(done1); end
    chk("abort busy cycles", nb, 0);
    chk("abort done pulses", nd, 0);
    for (int i = 0; i < 16; i++) put(0, 12'(i), 0, 12'(i));
    repeat (400) begin
      we_a = 1'($urandom_range(0, 1));
      addr_a = $urandom_range(0, 1) ? 12'($urandom_range(0, 19)) : 12'($urandom_range(0, 4095));
      addr_b = $urandom_range(0, 1) ? 12'($urandom_range(0, 19)) : 12'($urandom_range(0, 4095));
      data_a = 8'($urandom);
      clr_value = 8'($urandom);
      clr_start = $urandom_range(0, 40) == 0;
      rst_n = $urandom_range(0, 150) != 0;
      cyc();
    end
    rst_n = 1'b1; we_a = 1'b0; clr_start = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_mem_clr.md
VGA_MEM_CLR -- requirements
Module: vga_mem_clr

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning the address width of both ports.
REQ-003 The block SHALL have parameter DEPTH, default 2**ADDR_W, meaning the number of words, legal range 2..2**ADDR_W.
REQ-004 The block SHALL have parameter RDW_NEW, default 1, meaning same-address read-during-write returns new data when 1 and old data when 0.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 The ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- data_a  in  DATA_W  port A write data
- addr_a  in  ADDR_W  port A address
- we_a  in  1  port A write enable
- q_a  out  DATA_W  port A registered read data
- addr_b  in  ADDR_W  port B (read-only) address
- q_b  out  DATA_W  port B registered read data
- clr_start  in  1  request a fill of the whole memory
- clr_value  in  DATA_W  fill word, sampled with clr_start
- clr_busy  out  1  fill in progress
- clr_done  out  1  one-cycle pulse when the fill completes

Function
REQ-007 Both read ports SHALL have 1-cycle latency: q_x after edge N reflects addr_x sampled at edge N.
REQ-008 A port A write with we_a=1 and addr_a<DEPTH in IDLE SHALL store data_a at addr_a at the clock edge.
REQ-009 With RDW_NEW=1, q_a on a write cycle SHALL equal data_a; with RDW_NEW=0, it SHALL equal the prior contents.
REQ-010 If addr_b equals the address written that cycle (by port A or the fill engine), q_b SHALL follow the same RDW_NEW rule.
REQ-011 Out-of-range addresses (>=DEPTH) SHALL have the following behaviour:
- writes are ignored and leave memory unchanged
- reads return 0 on the next cycle
REQ-012 The fill FSM SHALL have the states IDLE, CLEAR and DONE.
REQ-013 In IDLE, clr_start=1 SHALL latch clr_value, zero the fill pointer and move the FSM to CLEAR.
REQ-014 In CLEAR, each cycle SHALL write the latched value at the pointer and increment it.
REQ-015 On the cycle writing DEPTH-1, the FSM SHALL move to DONE.
REQ-016 DONE SHALL assert clr_done for exactly one cycle, then move the FSM to IDLE.
REQ-017 clr_busy SHALL be 1 exactly while the FSM is in CLEAR, which lasts DEPTH cycles; clr_done is 0 elsewhere.
REQ-018 clr_start SHALL be ignored while in CLEAR or DONE; no restart and no relatch occur.
REQ-019 In CLEAR, we_a SHALL be ignored; the fill engine owns the write path and port A writes are dropped, not queued.
REQ-020 In CLEAR, port A and port B reads SHALL remain serviced at 1-cycle latency.
REQ-021 The fill pointer SHALL be ADDR_W bits wide and SHALL never wrap past DEPTH-1.
REQ-022 clr_start and we_a asserted in the same IDLE cycle SHALL give the following behaviour:
- the port A write completes
- the fill then starts on the next cycle and overwrites it

Reset
REQ-023 When rst_n=0 at a clock edge, q_a, q_b, clr_busy and clr_done SHALL be 0, the FSM SHALL be in IDLE and the pointer SHALL be 0.
REQ-024 Memory contents SHALL NOT be reset.
REQ-025 Reset during CLEAR SHALL abort the fill and leave already-filled words filled and the rest unchanged; clr_done SHALL NOT pulse.

Verification
REQ-026 The bench SHALL cover write then read: write 200 @0 via A, then read @0 on B -> q_a=200 the same cycle (RDW_NEW=1) and q_b=200 the next cycle.
REQ-027 The bench SHALL cover independent ports: write 37 @23, then set addr_a=23 and addr_b=24 with 24 unwritten-then-written 5 -> q_a=37, q_b=5.
REQ-028 The bench SHALL cover collision: A writes 37 @1 while addr_b=1 -> q_b=37 with RDW_NEW=1 and q_b=the old value with RDW_NEW=0.
REQ-029 The bench SHALL cover a full fill with DEPTH=16:
- stimulus: clr_start with clr_value=0xAA
- required: clr_busy high for exactly 16 cycles, then clr_done for 1 cycle
- required: all 16 addresses read 0xAA
- required: we_a during busy has no effect
- required: a second clr_start during busy is ignored
REQ-030 The bench SHALL cover reset mid-fill: rst_n low after 5 fill cycles -> busy=0 and done never pulses; addresses 0-4 read the fill value and 5-15 keep their old data.
REQ-031 The bench SHALL cover sweep and range with ADDR_W=12, DEPTH=2048:
- stimulus: write then read i for i=0..2095 on both ports
- required: 0..2047 match
- required: 2048..2095 read 0 and do not alias into low addresses
